wgt_load_ctrl: RTL and testbench

// - Sequences loading of a NUM_ROW x TAPS weight kernel from the shared weight SRAM into NUM_ROW 3-tap weight shift register files.
// - One start pulse fetches NUM_ROW*TAPS bytes over a req/gnt memory port.
// - Each byte returned is steered to one row by a one-hot shift-enable (wgt_read) that shifts that row's register file.
// - Sits between the layer scheduler (start/done) and the PE-row weight register files.

---
 rtl/wgt_ctrl_pkg.sv | 25 ++
 rtl/wgt_idx_cnt.sv | 61 ++++++
 rtl/wgt_load_ctrl.sv | 155 +++++++++++++++
 tb/tb_wgt_load_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wgt_ctrl_pkg.sv
// Shared definitions for the weight-load controller.
//   wgt_ld_state_e : load sequencer states
//   NUM_ROW/TAPS/AW/DW : default kernel geometry and memory widths
//   NWGT           : bytes fetched per kernel load
//   idx_w()        : index width for a counter of n values (never below 1)
package wgt_ctrl_pkg;

    localparam int NUM_ROW = 3;
    localparam int TAPS    = 3;
    localparam int AW      = 12;
    localparam int DW      = 8;
    localparam int NWGT    = NUM_ROW * TAPS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } wgt_ld_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wgt_idx_cnt.sv
// Nested tap/row index counter for the issue side of the weight loader.
// The tap index runs 0..TAPS-1 and carries into the row index 0..NUM_ROW-1,
// so the row of weight k is available without dividing k by TAPS.
//   clk, rstn : clock, asynchronous active-low reset
//   clr       : return to (row 0, tap 0); has priority over inc
//   inc       : advance one weight
//   row       : current row index
//   last      : current index is the final weight of the kernel
module wgt_idx_cnt
    import wgt_ctrl_pkg::*;
#(
    parameter int NUM_ROW = wgt_ctrl_pkg::NUM_ROW,
    parameter int TAPS    = wgt_ctrl_pkg::TAPS,
    parameter int RW      = idx_w(NUM_ROW)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    input  logic          inc,
    output logic [RW-1:0] row,
    output logic          last
);

    localparam int TW = idx_w(TAPS);

    logic [TW-1:0] tap_q, tap_d;
    logic [RW-1:0] row_q, row_d;
    logic          tap_wrap;

    assign tap_wrap = (tap_q == TW'(TAPS - 1));

    always_comb begin
        tap_d = tap_q;
        row_d = row_q;
        if (clr) begin
            tap_d = '0;
            row_d = '0;
        end else if (inc) begin
            if (tap_wrap) begin
                tap_d = '0;
                row_d = (row_q == RW'(NUM_ROW - 1)) ? '0 : row_q + RW'(1);
            end else begin
                tap_d = tap_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tap_q <= '0;
            row_q <= '0;
        end else begin
            tap_q <= tap_d;
            row_q <= row_d;
        end
    end

    assign row  = row_q;
    assign last = tap_wrap && (row_q == RW'(NUM_ROW - 1));

endmodule

// File: rtl/wgt_load_ctrl.sv
// Weight-load controller: on a start pulse, fetches a NUM_ROW x TAPS kernel
// from the weight SRAM (req/gnt port, read data one cycle after accept) and
// steers each returned byte into its row's shift register file through a
// one-hot shift enable.
//   clk, rstn            : clock, asynchronous active-low reset
//   start, base_addr     : begin a load at base_addr (accepted only in IDLE)
//   abort                : drop the current load, back to IDLE next cycle
//   mem_req/addr/gnt     : SRAM read request port
//   mem_rdata            : SRAM read data
//   wgt_data             : weight byte broadcast to all rows (= mem_rdata)
//   wgt_read             : one-hot row shift enable
//   busy, done           : load in progress / load complete pulse
module wgt_load_ctrl
    import wgt_ctrl_pkg::*;
#(
    parameter int NUM_ROW = wgt_ctrl_pkg::NUM_ROW,
    parameter int TAPS    = wgt_ctrl_pkg::TAPS,
    parameter int AW      = wgt_ctrl_pkg::AW,
    parameter int DW      = wgt_ctrl_pkg::DW
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic [AW-1:0]      base_addr,
    input  logic               abort,
    output logic               mem_req,
    output logic [AW-1:0]      mem_addr,
    input  logic               mem_gnt,
    input  logic [DW-1:0]      mem_rdata,
    output logic [DW-1:0]      wgt_data,
    output logic [NUM_ROW-1:0] wgt_read,
    output logic               busy,
    output logic               done
);

    localparam int RW = idx_w(NUM_ROW);

    wgt_ld_state_e      state_q, state_d;
    logic               mem_req_q, mem_req_d;
    logic [AW-1:0]      mem_addr_q, mem_addr_d;
    logic [NUM_ROW-1:0] wgt_read_q, wgt_read_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               cnt_clr, cnt_inc, cnt_last;
    logic [RW-1:0]      cnt_row;
    logic [NUM_ROW-1:0] row_hot;
    logic               accept;

    wgt_idx_cnt #(
        .NUM_ROW (NUM_ROW),
        .TAPS    (TAPS),
        .RW      (RW)
    ) u_idx_cnt (
        .clk  (clk),
        .rstn (rstn),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .row  (cnt_row),
        .last (cnt_last)
    );

    // Row index of the address being issued, decoded one-hot.
    for (genvar gi = 0; gi < NUM_ROW; gi++) begin : g_row_hot
        assign row_hot[gi] = (cnt_row == RW'(gi));
    end

    // mem_req is only ever high in FETCH, so this is the address accept.
    assign accept = mem_req_q & mem_gnt;

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        wgt_read_d = '0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = FETCH;
                    mem_req_d  = 1'b1;
                    mem_addr_d = base_addr;
                    busy_d     = 1'b1;
                    cnt_clr    = 1'b1;
                end
            end
            FETCH: begin
                if (accept) begin
                    cnt_inc    = 1'b1;
                    // Data returns next cycle; the registered one-hot lines up with it.
                    wgt_read_d = row_hot;
                    mem_addr_d = mem_addr_q + AW'(1);
                    if (cnt_last) begin
                        state_d   = DRAIN;
                        mem_req_d = 1'b0;
                    end
                end
            end
            DRAIN: begin
                // The final byte is being shifted in during this cycle.
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides everything, including a start in IDLE and any
        // return still in flight.
        if (abort) begin
            state_d    = IDLE;
            mem_req_d  = 1'b0;
            wgt_read_d = '0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            cnt_clr    = 1'b1;
            cnt_inc    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            wgt_read_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            wgt_read_q <= wgt_read_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign wgt_read = wgt_read_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign wgt_data = mem_rdata;

endmodule

// File: tb/tb_wgt_load_ctrl.sv
// Directed self-checking bench for wgt_load_ctrl with an SRAM model and a
// model of the three 3-tap weight shift register files.
module tb_wgt_load_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [11:0] base_addr;
    logic        abort;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic        mem_gnt;
    logic [7:0]  mem_rdata;
    logic [7:0]  wgt_data;
    logic [2:0]  wgt_read;
    logic        busy;
    logic        done;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] mem [4096];
    logic [7:0] rf  [3][3];
    int         acc_cnt  = 0;
    int         done_cnt = 0;

    always #5 clk = ~clk;

    wgt_load_ctrl dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .base_addr (base_addr),
        .abort     (abort),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_gnt   (mem_gnt),
        .mem_rdata (mem_rdata),
        .wgt_data  (wgt_data),
        .wgt_read  (wgt_read),
        .busy      (busy),
        .done      (done)
    );

    // SRAM: data valid exactly one cycle after accept; filler otherwise.
    // Register files: shift toward buf[2] on their row enable.
    always @(posedge clk) begin
        if (mem_req && mem_gnt) begin
            mem_rdata <= mem[mem_addr];
            acc_cnt   <= acc_cnt + 1;
        end else begin
            mem_rdata <= 8'hEE;
        end
        if (done) done_cnt <= done_cnt + 1;
        for (int r = 0; r < 3; r++) begin
            if (wgt_read[r]) begin
                rf[r][0] <= wgt_data;
                rf[r][1] <= rf[r][0];
                rf[r][2] <= rf[r][1];
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rstn = 1'b0; start = 1'b0; abort = 1'b0; mem_gnt = 1'b1; base_addr = 12'h0;
        #2;
        tests_run++;
        if ({mem_req, mem_addr, wgt_read, busy, done} !== 18'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs got %h exp 0", {mem_req, mem_addr, wgt_read, busy, done});
        end
        step; step;
        rstn = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step;
            tests_run++;
            if ({mem_req, wgt_read, done, busy} !== 6'b0) begin
                tests_failed++;
                $display("FAIL idle c%0d req/rd/done/busy got %b exp 000000", c, {mem_req, wgt_read, done, busy});
            end
        end
    endtask

    // Full load with gnt tied high; checks the cycle-exact latency table
    // and the final register-file contents. Entered and left mid-cycle.
    task automatic test_load(input logic [11:0] base, input logic [7:0] first, input string name);
        logic [11:0] exp_addr;
        logic [2:0]  exp_wr;
        logic [7:0]  exp_data;
        logic [7:0]  e;
        mem_gnt = 1'b1; base_addr = base; start = 1'b1;
        step;
        start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            exp_addr = base + 12'(c - 1);
            exp_wr   = (c >= 2 && c <= 10) ? 3'(1 << ((c - 2) / 3)) : 3'b000;
            exp_data = first + 8'(c - 2);
            tests_run++;
            if (mem_req !== (c <= 9)) begin
                tests_failed++;
                $display("FAIL %s c%0d mem_req got %b exp %b", name, c, mem_req, (c <= 9));
            end
            if (c <= 9) begin
                tests_run++;
                if (mem_addr !== exp_addr) begin
                    tests_failed++;
                    $display("FAIL %s c%0d mem_addr got %h exp %h", name, c, mem_addr, exp_addr);
                end
            end
            tests_run++;
            if (wgt_read !== exp_wr) begin
                tests_failed++;
                $display("FAIL %s c%0d wgt_read got %b exp %b", name, c, wgt_read, exp_wr);
            end
            if (exp_wr != 3'b000) begin
                tests_run++;
                if (wgt_data !== exp_data) begin
                    tests_failed++;
                    $display("FAIL %s c%0d wgt_data got %h exp %h", name, c, wgt_data, exp_data);
                end
            end
            tests_run++;
            if (busy !== (c <= 10) || done !== (c == 11)) begin
                tests_failed++;
                $display("FAIL %s c%0d busy/done got %b%b exp %b%b", name, c, busy, done, (c <= 10), (c == 11));
            end
            step;
        end
        for (int r = 0; r < 3; r++) begin
            e = first + 8'(3 * r);
            tests_run++;
            if ({rf[r][2], rf[r][1], rf[r][0]} !== {e, e + 8'd1, e + 8'd2}) begin
                tests_failed++;
                $display("FAIL %s rf_row%0d got %h exp %h", name, r, {rf[r][2], rf[r][1], rf[r][0]}, {e, e + 8'd1, e + 8'd2});
            end
        end
    endtask

    // gnt alternates 1,0,1,0...: accepts on odd cycles 1..17, done at 19.
    task automatic test_gnt_toggle;
        int         acc = 0;
        int         pulses = 0;
        int         done_cyc = -1;
        int         dones = 0;
        logic       pend = 1'b0;
        logic [2:0] pend_hot = 3'b000;
        logic [2:0] exp_wr;
        logic [7:0] e;
        base_addr = 12'h100; start = 1'b1;
        step;
        start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            mem_gnt = c[0];
            exp_wr = pend ? pend_hot : 3'b000;
            tests_run++;
            if (wgt_read !== exp_wr) begin
                tests_failed++;
                $display("FAIL gnt_toggle c%0d wgt_read got %b exp %b", c, wgt_read, exp_wr);
            end
            if (exp_wr != 3'b000) begin
                tests_run++;
                if (wgt_data !== 8'(pulses + 1)) begin
                    tests_failed++;
                    $display("FAIL gnt_toggle c%0d wgt_data got %h exp %h", c, wgt_data, 8'(pulses + 1));
                end
                pulses++;
            end
            tests_run++;
            if (mem_req !== (acc < 9) || (acc < 9 && mem_addr !== 12'h100 + 12'(acc))) begin
                tests_failed++;
                $display("FAIL gnt_toggle c%0d req/addr got %b/%h exp %b/%h", c, mem_req, mem_addr, (acc < 9), 12'h100 + 12'(acc));
            end
            if (done === 1'b1) begin
                dones++;
                done_cyc = c;
            end
            pend = 1'b0;
            if (mem_req && mem_gnt && acc < 9) begin
                pend_hot = 3'(1 << (acc / 3));
                pend = 1'b1;
                acc++;
            end
            step;
        end
        mem_gnt = 1'b1;
        tests_run++;
        if (pulses != 9 || acc != 9 || dones != 1 || done_cyc != 19) begin
            tests_failed++;
            $display("FAIL gnt_toggle totals pulses/acc/dones/done_cyc got %0d/%0d/%0d/%0d exp 9/9/1/19", pulses, acc, dones, done_cyc);
        end
        for (int r = 0; r < 3; r++) begin
            e = 8'(3 * r + 1);
            tests_run++;
            if ({rf[r][2], rf[r][1], rf[r][0]} !== {e, e + 8'd1, e + 8'd2}) begin
                tests_failed++;
                $display("FAIL gnt_toggle rf_row%0d got %h exp %h", r, {rf[r][2], rf[r][1], rf[r][0]}, {e, e + 8'd1, e + 8'd2});
            end
        end
    endtask

    // Extra starts at cycles 4 and 11 are ignored; start at 12 loads 0x200.
    task automatic test_back_to_back;
        int         acc0;
        int         done0;
        logic [7:0] e;
        acc0 = acc_cnt; done0 = done_cnt;
        mem_gnt = 1'b1; base_addr = 12'h100; start = 1'b1;
        step;
        start = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            if (c == 5) begin
                tests_run++;
                if (busy !== 1'b1 || mem_addr !== 12'h104) begin
                    tests_failed++;
                    $display("FAIL b2b c5 busy/addr got %b/%h exp 1/104", busy, mem_addr);
                end
            end
            if (c == 12) begin
                tests_run++;
                if (mem_req !== 1'b0 || busy !== 1'b0 || acc_cnt - acc0 != 9 || done_cnt - done0 != 1) begin
                    tests_failed++;
                    $display("FAIL b2b c12 req/busy/acc/done got %b/%b/%0d/%0d exp 0/0/9/1", mem_req, busy, acc_cnt - acc0, done_cnt - done0);
                end
            end
            if (c == 13) begin
                tests_run++;
                if (mem_req !== 1'b1 || mem_addr !== 12'h200) begin
                    tests_failed++;
                    $display("FAIL b2b c13 req/addr got %b/%h exp 1/200", mem_req, mem_addr);
                end
            end
            if (c == 23) begin
                tests_run++;
                if (done !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL b2b c23 done got %b exp 1", done);
                end
            end
            if (c == 24) begin
                tests_run++;
                if (acc_cnt - acc0 != 18 || done_cnt - done0 != 2) begin
                    tests_failed++;
                    $display("FAIL b2b totals acc/done got %0d/%0d exp 18/2", acc_cnt - acc0, done_cnt - done0);
                end
            end
            start = (c == 4 || c == 11 || c == 12);
            if (c == 12) base_addr = 12'h200;
            step;
        end
        start = 1'b0;
        for (int r = 0; r < 3; r++) begin
            e = 8'h21 + 8'(3 * r);
            tests_run++;
            if ({rf[r][2], rf[r][1], rf[r][0]} !== {e, e + 8'd1, e + 8'd2}) begin
                tests_failed++;
                $display("FAIL b2b rf_row%0d got %h exp %h", r, {rf[r][2], rf[r][1], rf[r][0]}, {e, e + 8'd1, e + 8'd2});
            end
        end
    endtask

    // Abort high during cycle 5; then a clean reload.
    task automatic test_abort;
        int done0;
        done0 = done_cnt;
        mem_gnt = 1'b1; base_addr = 12'h100; start = 1'b1;
        step;
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 5) begin
                tests_run++;
                if (busy !== 1'b1 || wgt_read !== 3'b010) begin
                    tests_failed++;
                    $display("FAIL abort c5 busy/wgt_read got %b/%b exp 1/010", busy, wgt_read);
                end
            end
            if (c >= 6) begin
                tests_run++;
                if (mem_req !== 1'b0 || wgt_read !== 3'b000 || busy !== 1'b0 || done !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL abort c%0d req/rd/busy/done got %b/%b/%b/%b exp 0/000/0/0", c, mem_req, wgt_read, busy, done);
                end
            end
            abort = (c == 5);
            step;
        end
        abort = 1'b0;
        tests_run++;
        if (done_cnt != done0) begin
            tests_failed++;
            $display("FAIL abort done_count got %0d exp %0d", done_cnt - done0, 0);
        end
        test_load(12'h100, 8'h01, "reload");
    endtask

    task automatic test_wrap_and_async_reset;
        int done0;
        test_load(12'hFFE, 8'h41, "wrap");
        done0 = done_cnt;
        mem_gnt = 1'b1; base_addr = 12'hFFE; start = 1'b1;
        step;
        start = 1'b0;
        step; step; step;
        #3;
        rstn = 1'b0;
        #1;
        tests_run++;
        if ({mem_req, mem_addr, wgt_read, busy, done} !== 18'h0) begin
            tests_failed++;
            $display("FAIL async_reset outputs got %h exp 0", {mem_req, mem_addr, wgt_read, busy, done});
        end
        step;
        rstn = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step;
            tests_run++;
            if (mem_req !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL post_reset c%0d req/done/busy got %b/%b/%b exp 0/0/0", c, mem_req, done, busy);
            end
        end
        tests_run++;
        if (done_cnt != done0) begin
            tests_failed++;
            $display("FAIL post_reset done_count got %0d exp 0", done_cnt - done0);
        end
        test_load(12'h200, 8'h21, "after_reset");
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
        for (int r = 0; r < 3; r++)
            for (int t = 0; t < 3; t++) rf[r][t] = 8'h00;
        for (int k = 0; k < 9; k++) begin
            mem[12'h100 + 12'(k)] = 8'(k + 1);
            mem[12'h200 + 12'(k)] = 8'h21 + 8'(k);
            mem[12'hFFE + 12'(k)] = 8'h41 + 8'(k);
        end
        test_reset;
        test_load(12'h100, 8'h01, "basic");
        test_gnt_toggle;
        test_back_to_back;
        test_abort;
        test_wrap_and_async_reset;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
